mux_serializer: RTL and testbench
=================================

MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 SHALL have parameter IDLE_LEVEL, default 1'b0; ser_out level whenever ser_vld is low.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  8  parallel word to serialize.
REQ-005 SHALL have port in_valid  input  1  in_data is offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port flush  input  1  synchronous abort of the current frame.
REQ-008 SHALL have port s  output  3  bit-select index, drives the downstream 8:1 mux select.
REQ-009 SHALL have port word_q  output  8  registered word, drives the downstream 8:1 mux data input.
REQ-010 SHALL have port ser_out  output  1  serial bit (word_q[s] during data bits).
REQ-011 SHALL have port ser_vld  output  1  ser_out carries a frame bit.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse with the last bit of a frame.

Function
REQ-013 SHALL implement states IDLE, SHIFT and, with PARITY_EN only, PAR.
REQ-014 SHALL drive in_ready high exactly when state is IDLE and flush is low.
REQ-015 SHALL, on a rising edge with in_valid and in_ready both high: word_q <= in_data, s <= 0, state -> SHIFT.
REQ-016 SHALL in SHIFT drive ser_vld=1 and ser_out=word_q[s] (LSB first), combinationally from registers.
REQ-017 SHALL in SHIFT increment s by 1 per clock while s<7; s never wraps within a frame.
REQ-018 SHALL at s==7 in SHIFT move to PAR (PARITY_EN) or IDLE (otherwise) on the next edge, with s held at 7.
REQ-019 SHALL assert frame_done only in the cycle the final frame bit is on ser_out.
REQ-020 SHALL ignore in_valid outside IDLE; word_q stays stable for the whole frame.
REQ-021 SHALL give flush priority over all transitions: next edge -> IDLE, s <= 0, no frame_done, word_q unchanged.
REQ-022 SHALL, with flush high in IDLE, refuse new words (in_ready low).
REQ-023 SHALL in IDLE drive ser_vld=0, frame_done=0, ser_out=IDLE_LEVEL.
REQ-024 SHALL allow at most one word per 9 cycles (10 with PARITY_EN): IDLE accept cycle plus 8 (9) bit cycles.

Reset
REQ-025 SHALL on rst_n low immediately force state=IDLE, s=0, word_q=0, ser_vld=0, frame_done=0, ser_out=IDLE_LEVEL, in_ready=1.
REQ-026 SHALL discard any frame in progress on reset; first accept possible on the first edge after rst_n rises.

Configuration
REQ-027 SHALL, with macro MUX_SERIALIZER_PARITY_EN defined, append one PAR cycle after bit 7 with ser_out = even parity (XOR of word_q), ser_vld=1, frame_done=1.
REQ-028 SHALL, without MUX_SERIALIZER_PARITY_EN, contain no PAR state; frame is 8 bits, frame_done with bit 7.

Verification
REQ-029 Reset: rst_n low mid-SHIFT at s=4 -> s=0, ser_vld=0, in_ready=1 immediately, without a clock edge.
REQ-030 Serialize: in_data=8'b10110110, in_valid 1 cycle -> s=0..7, ser_out 0,1,1,0,1,1,0,1, frame_done with s=7.
REQ-031 Parity (macro on): same word -> 9th bit ser_out=1, frame_done on that cycle, then IDLE.
REQ-032 Back-to-back: in_valid held high with 8'hA5 then 8'h3C -> second accepted exactly on the first IDLE cycle after frame 1, no gap bit lost.
REQ-033 Flush: flush at s=3 -> IDLE next edge, no frame_done, in_valid during flush not accepted.
REQ-034 Busy ignore: in_valid with 8'hFF during SHIFT of 8'h00 -> all ser_out 0, word_q stays 8'h00.

Source files
------------

// File: rtl/mux_serializer.sv
// 8-bit LSB-first serializer that drives a downstream 8:1 mux through s/word_q.
// Define MUX_SERIALIZER_PARITY_EN to append an even-parity bit after bit 7.
module mux_serializer #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [2:0] s,
  output logic [7:0] word_q,
  output logic       ser_out,
  output logic       ser_vld,
  output logic       frame_done
);

`ifdef MUX_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s      <= '0;
      word_q <= '0;
    end else if (flush) begin
      state <= IDLE;
      s     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q <= in_data;
            s      <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (s != 3'd7) begin
            s <= s + 3'd1;
          end else begin
`ifdef MUX_SERIALIZER_PARITY_EN
            state <= PAR;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef MUX_SERIALIZER_PARITY_EN
        PAR:     state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // An aborted frame never reports completion, even if flushed on its last bit.
  always_comb begin
    in_ready   = (state == IDLE) && !flush;
    ser_vld    = 1'b0;
    ser_out    = IDLE_LEVEL;
    frame_done = 1'b0;
    case (state)
      SHIFT: begin
        ser_vld = 1'b1;
        ser_out = word_q[s];
`ifndef MUX_SERIALIZER_PARITY_EN
        frame_done = (s == 3'd7) && !flush;
`endif
      end
`ifdef MUX_SERIALIZER_PARITY_EN
      PAR: begin
        ser_vld    = 1'b1;
        ser_out    = ^word_q;
        frame_done = !flush;
      end
`endif
      default: begin
        ser_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench for mux_serializer: driver queues hand-computed serial beats,
// a negedge monitor pops and compares them whenever ser_vld is high.
module tb_mux_serializer;

  localparam logic IDLE_LV = 1'b1;
`ifdef MUX_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME_BITS = 9;
`else
  localparam int unsigned FRAME_BITS = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [2:0] s;
  logic [7:0] word_q;
  logic       ser_out;
  logic       ser_vld;
  logic       frame_done;

  mux_serializer #(.IDLE_LEVEL(IDLE_LV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .s          (s),
    .word_q     (word_q),
    .ser_out    (ser_out),
    .ser_vld    (ser_vld),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bit_v;
    logic [2:0] idx;
    logic       done;
  } beat_t;

  beat_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // seq[7] is the first bit on the line; nbits beats are expected.
  task automatic push_frame(input logic [7:0] seq, input logic par,
                            input int unsigned nbits, input logic full);
    beat_t b;
    for (int i = 0; i < int'(nbits); i++) begin
      b.bit_v = seq[7-i];
      b.idx   = 3'(i);
`ifdef MUX_SERIALIZER_PARITY_EN
      b.done  = 1'b0;
`else
      b.done  = full && (i == 7);
`endif
      exp_q.push_back(b);
    end
`ifdef MUX_SERIALIZER_PARITY_EN
    if (full) begin
      b.bit_v = par;
      b.idx   = 3'd7;
      b.done  = 1'b1;
      exp_q.push_back(b);
    end
`else
    if (par === 1'bx) $display("parity value unknown");
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  beat_t got;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ser_vld) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=ser_vld=1 s=%0d required=no beat @%0t", s, $time);
        end else begin
          got = exp_q.pop_front();
          chk("ser_out", 8'(ser_out), 8'(got.bit_v));
          chk("s", 8'(s), 8'(got.idx));
          chk("frame_done", 8'(frame_done), 8'(got.done));
        end
      end else begin
        chk("idle_ser_out", 8'(ser_out), 8'(IDLE_LV));
        chk("idle_frame_done", 8'(frame_done), 8'h00);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0;
    #3;
    chk("rst_s", 8'(s), 8'h00);
    chk("rst_word_q", word_q, 8'h00);
    chk("rst_ser_vld", 8'(ser_vld), 8'h00);
    chk("rst_frame_done", 8'(frame_done), 8'h00);
    chk("rst_ser_out", 8'(ser_out), 8'(IDLE_LV));
    chk("rst_in_ready", 8'(in_ready), 8'h01);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Basic frame: 10110110 -> 0,1,1,0,1,1,0,1, parity 1
    in_data = 8'b10110110; in_valid = 1'b1;
    chk("ready_idle", 8'(in_ready), 8'h01);
    push_frame(8'b01101101, 1'b1, 8, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ser_word_q", word_q, 8'hB6);
    chk("ser_first_s", 8'(s), 8'h00);
    repeat (FRAME_BITS) step();
    chk("ser_end_vld", 8'(ser_vld), 8'h00);
    chk("ser_end_ready", 8'(in_ready), 8'h01);

    // Back-to-back A5 then 3C with in_valid held
    in_data = 8'hA5; in_valid = 1'b1;
    push_frame(8'b10100101, 1'b0, 8, 1'b1);
    step();
    in_data = 8'h3C;
    push_frame(8'b00111100, 1'b0, 8, 1'b1);
    chk("b2b_busy_ready", 8'(in_ready), 8'h00);
    repeat (FRAME_BITS) step();
    chk("b2b_gap_ready", 8'(in_ready), 8'h01);
    chk("b2b_gap_vld", 8'(ser_vld), 8'h00);
    chk("b2b_gap_word", word_q, 8'hA5);
    step();
    in_valid = 1'b0;
    chk("b2b_second_word", word_q, 8'h3C);
    chk("b2b_second_s", 8'(s), 8'h00);
    chk("b2b_second_vld", 8'(ser_vld), 8'h01);
    repeat (FRAME_BITS) step();

    // Busy ignore: FF offered during 00 frame
    in_data = 8'h00; in_valid = 1'b1;
    push_frame(8'h00, 1'b0, 8, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    in_data = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("busy_ready", 8'(in_ready), 8'h00);
      step();
    end
    chk("busy_word_q", word_q, 8'h00);
    in_valid = 1'b0;
    repeat (FRAME_BITS - 4) step();
    chk("busy_word_after", word_q, 8'h00);
    chk("busy_idle_vld", 8'(ser_vld), 8'h00);

    // Flush at s=3 of C3 (beats 1,1,0,0 then abort)
    in_data = 8'hC3; in_valid = 1'b1;
    push_frame(8'b11000011, 1'b0, 4, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("flush_at_s", 8'(s), 8'h03);
    flush = 1'b1; in_data = 8'h77; in_valid = 1'b1;
    #1;
    chk("flush_ready", 8'(in_ready), 8'h00);
    chk("flush_no_done", 8'(frame_done), 8'h00);
    step();
    chk("flush_idle_vld", 8'(ser_vld), 8'h00);
    chk("flush_s", 8'(s), 8'h00);
    chk("flush_idle_ready", 8'(in_ready), 8'h00);
    chk("flush_word_q", word_q, 8'hC3);
    step();
    chk("flush_refuse_vld", 8'(ser_vld), 8'h00);
    chk("flush_refuse_word", word_q, 8'hC3);
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Asynchronous reset at s=4 of 5A (beats 0,1,0,1,1)
    in_data = 8'h5A; in_valid = 1'b1;
    push_frame(8'b01011010, 1'b0, 5, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("prerst_s", 8'(s), 8'h04);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", 8'(s), 8'h00);
    chk("arst_vld", 8'(ser_vld), 8'h00);
    chk("arst_ready", 8'(in_ready), 8'h01);
    chk("arst_word_q", word_q, 8'h00);
    chk("arst_ser_out", 8'(ser_out), 8'(IDLE_LV));
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_data = 8'b10110110; in_valid = 1'b1;
    push_frame(8'b01101101, 1'b1, 8, 1'b1);
    step();
    in_valid = 1'b0;
    chk("post_rst_accept_word", word_q, 8'hB6);
    chk("post_rst_accept_vld", 8'(ser_vld), 8'h01);
    repeat (FRAME_BITS) step();
    repeat (2) step();

    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
